run_ctrl_debounce: RTL and testbench
====================================

// Module: run_ctrl_debounce
// PURPOSE
//   Upstream control stage for the cascaded counter chain. Debounces two raw push-buttons
//   (run/pause, clear), turns presses into one-cycle events, and drives a 4-state FSM that
//   produces the counter chain's level enable and active-low clear. Replaces direct
//   switch wiring of enable/clr at the top level.
// PARAMETERS
//   DB_BITS     20         width of each debounce counter
//   DB_MAX      20'd999999 debounce terminal count; input must be steady DB_MAX+1 cycles (20 ms @ 50 MHz)
//   CLR_BITS    3          width of clear-pulse counter
//   CLR_CYCLES  3'd4       cycles clr_n is held low per clear event (1..2^CLR_BITS-1)
// PORTS
//   clk         in   1  system clock (CK50M at top); one clock domain, all state on rising edge
//   clr         in   1  reset, asynchronous, active-low
//   key_run     in   1  raw run/pause button, active-low (pressed = 0), asynchronous to clk
//   key_clr     in   1  raw clear button, active-low, asynchronous to clk
//   enable      out  1  level enable to first counter stage; 1 only in RUN
//   clr_n       out  1  active-low synchronous-pulse clear to counter chain; 0 in CLEAR
//   state       out  2  FSM state for LEDs: 00 IDLE, 01 RUN, 10 PAUSE, 11 CLEAR
// BEHAVIOUR
//   Interface: one clock; reset is asynchronous and active-low.
//   Reset (clr=0): sync flops=1, debounced levels=1 (released), debounce counters=0,
//     press pulses=0, clear counter=0, state=IDLE; enable=0, clr_n=0, state=00.
//     clr_n is a register: held 0 during reset, goes 1 on first rising edge after release.
//   Per key, identical logic:
//   - 2-flop synchroniser on raw input.
//   - Debounce: if synced != debounced level, counter increments; when counter==DB_MAX
//     and still mismatched, debounced level <= synced, counter <= 0. Any cycle with
//     synced == debounced level clears counter (glitch shorter than DB_MAX+1 is dropped).
//   - Press pulse: registered, 1 for exactly one cycle after debounced level goes 1->0.
//     Release (0->1) produces no event. Holding a key gives one event only.
//   Latency: number edges from 1 = first edge sampling new raw level; debounced level
//     updates at edge DB_MAX+3, press pulse high after DB_MAX+4, state/enable after DB_MAX+5.
//   FSM (Moore; enable = (state==RUN), clr_n registered = !(next_state==CLEAR)):
//     IDLE : run_ev -> RUN;   clr_ev -> CLEAR
//     RUN  : run_ev -> PAUSE; clr_ev -> CLEAR
//     PAUSE: run_ev -> RUN;   clr_ev -> CLEAR
//     CLEAR: clear counter counts 1..CLR_CYCLES; at CLR_CYCLES -> IDLE, counter <= 0;
//            all events ignored (dropped, not queued)
//   clr_n is 0 for exactly CLR_CYCLES consecutive cycles per clear event, aligned with
//     the CLEAR state; enable is 0 throughout CLEAR.
//   Simultaneous run_ev and clr_ev: clear wins (-> CLEAR), run_ev dropped.
//   Reset mid-operation (any state, any counter value): immediate return to reset values;
//     keys held low through reset release do not produce an event until released and re-pressed.
//   Counter wrap: debounce counter never exceeds DB_MAX; clear counter never exceeds CLR_CYCLES.
// TESTING (bench overrides DB_MAX=3, CLR_CYCLES=4)
//   1 Reset: clr=0 mid-RUN with counters nonzero -> enable=0, clr_n=0, state=00 same
//     instant; clr_n=1 on first edge after clr=1.
//   2 Clean press: key_run 1->0 held 10 cycles -> enable=1 exactly 8 edges after first
//     sampling edge, state=01; release -> no change; second press -> state=10, enable=0.
//   3 Bounce: key_run low 3 cycles then high, repeated 5x -> no event, state stays 00;
//     low 4+ cycles -> one event.
//   4 Clear: in RUN press key_clr -> state=11, clr_n=0 for exactly 4 cycles, enable=0,
//     then state=00, clr_n=1; key_run pressed during CLEAR -> ignored, stays IDLE.
//   5 Simultaneous: both keys pressed same cycle from PAUSE -> state=11, then 00 (not RUN).
//   6 Held key: key_run held low 100 cycles from IDLE -> exactly one transition to RUN.

Source files
------------

// File: rtl/run_ctrl_debounce.sv
// run_ctrl_debounce: debounces the run/pause and clear push-buttons, turns each
// debounced press into a one-cycle event, and sequences a 4-state control FSM
// that drives the counter chain's level enable and active-low clear pulse.

// Per-key conditioner: 2-flop synchroniser, debounce counter, press-event pulse.
module run_ctrl_key_db #(
  parameter int                 DB_BITS = 20,
  parameter logic [DB_BITS-1:0] DB_MAX  = 20'd999999
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_raw,   // active-low raw button, asynchronous to clk
  output logic press      // one-cycle pulse per debounced press
);

  logic               sync1_q, sync1_d;
  logic               sync2_q, sync2_d;
  logic               lvl_q, lvl_d;         // debounced level, 1 = released
  logic               lvl_dly_q, lvl_dly_d; // previous debounced level, for edge detect
  logic [DB_BITS-1:0] cnt_q, cnt_d;
  logic [1:0]         vld_q, vld_d;         // marks the synchroniser as flushed after reset
  logic               arm_q, arm_d;         // set once the key has been seen released
  logic               press_q, press_d;

  // Next-state logic for the synchroniser, debounce filter and press detector.
  always_comb begin
    sync1_d   = key_raw;
    sync2_d   = sync1_q;
    vld_d     = {vld_q[0], 1'b1};
    lvl_dly_d = lvl_q;
    lvl_d     = lvl_q;
    cnt_d     = '0;
    if (sync2_q != lvl_q) begin
      if (cnt_q >= DB_MAX) begin
        lvl_d = sync2_q;
        cnt_d = '0;
      end else begin
        lvl_d = lvl_q;
        cnt_d = cnt_q + DB_BITS'(1);
      end
    end else begin
      lvl_d = lvl_q;
      cnt_d = '0;
    end
    // A key held down across reset release must be let go before it can
    // produce an event, so events are gated until a genuine release is seen.
    if (arm_q) begin
      arm_d = 1'b1;
    end else begin
      arm_d = vld_q[1] & sync2_q & lvl_q;
    end
    press_d = arm_q & lvl_dly_q & ~lvl_q;
  end

  // Register all per-key state; reset leaves the key in the released state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      lvl_q     <= 1'b1;
      lvl_dly_q <= 1'b1;
      cnt_q     <= '0;
      vld_q     <= 2'b00;
      arm_q     <= 1'b0;
      press_q   <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      lvl_q     <= lvl_d;
      lvl_dly_q <= lvl_dly_d;
      cnt_q     <= cnt_d;
      vld_q     <= vld_d;
      arm_q     <= arm_d;
      press_q   <= press_d;
    end
  end

  assign press = press_q;

endmodule

module run_ctrl_debounce #(
  parameter int                  DB_BITS    = 20,
  parameter logic [DB_BITS-1:0]  DB_MAX     = 20'd999999,
  parameter int                  CLR_BITS   = 3,
  parameter logic [CLR_BITS-1:0] CLR_CYCLES = 3'd4
) (
  input  logic       clk,
  input  logic       clr,      // asynchronous active-low reset
  input  logic       key_run,
  input  logic       key_clr,
  output logic       enable,
  output logic       clr_n,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_CLEAR = 2'b11
  } state_e;

  logic                run_ev;
  logic                clr_ev;
  state_e              state_q, state_d;
  logic [CLR_BITS-1:0] clr_cnt_q, clr_cnt_d;
  logic                enable_q, enable_d;
  logic                clr_n_q, clr_n_d;

  run_ctrl_key_db #(.DB_BITS(DB_BITS), .DB_MAX(DB_MAX)) u_db_run (
    .clk     (clk),
    .rst_n   (clr),
    .key_raw (key_run),
    .press   (run_ev)
  );

  run_ctrl_key_db #(.DB_BITS(DB_BITS), .DB_MAX(DB_MAX)) u_db_clr (
    .clk     (clk),
    .rst_n   (clr),
    .key_raw (key_clr),
    .press   (clr_ev)
  );

  // State register together with the clear-length counter.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q   <= ST_IDLE;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // Next-state logic; a clear event beats a simultaneous run event.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      ST_IDLE, ST_PAUSE: begin
        if (clr_ev) begin
          state_d   = ST_CLEAR;
          clr_cnt_d = CLR_BITS'(1);
        end else if (run_ev) begin
          state_d   = ST_RUN;
        end else begin
          state_d   = state_q;
        end
      end
      ST_RUN: begin
        if (clr_ev) begin
          state_d   = ST_CLEAR;
          clr_cnt_d = CLR_BITS'(1);
        end else if (run_ev) begin
          state_d   = ST_PAUSE;
        end else begin
          state_d   = ST_RUN;
        end
      end
      ST_CLEAR: begin
        // Events arriving here are dropped; the counter alone ends the clear.
        if (clr_cnt_q >= CLR_CYCLES) begin
          state_d   = ST_IDLE;
          clr_cnt_d = '0;
        end else begin
          state_d   = ST_CLEAR;
          clr_cnt_d = clr_cnt_q + CLR_BITS'(1);
        end
      end
      default: begin
        state_d   = ST_IDLE;
        clr_cnt_d = '0;
      end
    endcase
  end

  // Output decode from the upcoming state so the registered outputs align with state_q.
  always_comb begin
    enable_d = (state_d == ST_RUN);
    clr_n_d  = (state_d != ST_CLEAR);
  end

  // Output registers; clr_n is held low while in reset.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      enable_q <= 1'b0;
      clr_n_q  <= 1'b0;
    end else begin
      enable_q <= enable_d;
      clr_n_q  <= clr_n_d;
    end
  end

  assign enable = enable_q;
  assign clr_n  = clr_n_q;
  assign state  = state_q;

endmodule

// File: tb/tb_run_ctrl_debounce.sv
// Directed bench for run_ctrl_debounce with DB_MAX=3 and CLR_CYCLES=4.
module tb_run_ctrl_debounce;

  logic       clk;
  logic       clr;
  logic       key_run;
  logic       key_clr;
  logic       enable;
  logic       clr_n;
  logic [1:0] state;

  int vectors;
  int miscompares;

  run_ctrl_debounce #(
    .DB_BITS    (20),
    .DB_MAX     (20'd3),
    .CLR_BITS   (3),
    .CLR_CYCLES (3'd4)
  ) dut (
    .clk     (clk),
    .clr     (clr),
    .key_run (key_run),
    .key_clr (key_clr),
    .enable  (enable),
    .clr_n   (clr_n),
    .state   (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [1:0] st, input logic en, input logic cn);
    chk({tag, ".state"},  state,         st);
    chk({tag, ".enable"}, {1'b0, enable}, {1'b0, en});
    chk({tag, ".clr_n"},  {1'b0, clr_n},  {1'b0, cn});
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    clr     = 1'b0;
    key_run = 1'b1;
    key_clr = 1'b1;

    // Power-on reset
    step(3);
    chk_all("por", 2'b00, 1'b0, 1'b0);
    clr = 1'b1;
    chk({"por_rel.clr_n_before_edge"}, {1'b0, clr_n}, 2'b00);
    step(1);
    chk_all("por_rel", 2'b00, 1'b0, 1'b1);
    step(4);

    // Bounce: 3-cycle lows are filtered out
    for (int i = 0; i < 5; i++) begin
      key_run = 1'b0;
      step(3);
      key_run = 1'b1;
      step(3);
    end
    step(10);
    chk_all("bounce", 2'b00, 1'b0, 1'b1);

    // 4-cycle low is long enough for one event: IDLE -> RUN at edge 8
    key_run = 1'b0;
    step(4);
    key_run = 1'b1;
    step(3);
    chk_all("press4.e7", 2'b00, 1'b0, 1'b1);
    step(1);
    chk_all("press4.e8", 2'b01, 1'b1, 1'b1);
    step(10);

    // Clear from RUN, with a run press landing inside CLEAR
    key_clr = 1'b0;
    step(4);
    key_run = 1'b0;
    step(3);
    chk_all("clear.e7", 2'b01, 1'b1, 1'b1);
    step(1);
    chk_all("clear.e8", 2'b11, 1'b0, 1'b0);
    key_clr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk_all("clear.hold", 2'b11, 1'b0, 1'b0);
    end
    step(1);
    chk_all("clear.done", 2'b00, 1'b0, 1'b1);
    step(1);
    chk_all("clear.run_dropped", 2'b00, 1'b0, 1'b1);
    key_run = 1'b1;
    step(15);
    chk_all("clear.settle", 2'b00, 1'b0, 1'b1);

    // Clean press: enable rises exactly at edge 8
    key_run = 1'b0;
    step(7);
    chk_all("clean.e7", 2'b00, 1'b0, 1'b1);
    step(1);
    chk_all("clean.e8", 2'b01, 1'b1, 1'b1);
    step(2);
    key_run = 1'b1;
    step(12);
    chk_all("clean.release", 2'b01, 1'b1, 1'b1);
    key_run = 1'b0;
    step(7);
    chk_all("pause.e7", 2'b01, 1'b1, 1'b1);
    step(1);
    chk_all("pause.e8", 2'b10, 1'b0, 1'b1);
    key_run = 1'b1;
    step(12);
    chk_all("pause.release", 2'b10, 1'b0, 1'b1);

    // Simultaneous presses from PAUSE: clear wins, ends in IDLE
    key_run = 1'b0;
    key_clr = 1'b0;
    step(8);
    chk_all("simul.e8", 2'b11, 1'b0, 1'b0);
    step(3);
    chk_all("simul.e11", 2'b11, 1'b0, 1'b0);
    step(1);
    chk_all("simul.e12", 2'b00, 1'b0, 1'b1);
    key_run = 1'b1;
    key_clr = 1'b1;
    step(15);
    chk_all("simul.settle", 2'b00, 1'b0, 1'b1);

    // Held key: one transition only
    key_run = 1'b0;
    step(8);
    chk_all("held.e8", 2'b01, 1'b1, 1'b1);
    step(92);
    chk_all("held.e100", 2'b01, 1'b1, 1'b1);
    key_run = 1'b1;
    step(15);
    chk_all("held.release", 2'b01, 1'b1, 1'b1);

    // Reset mid-RUN with the debounce counter running
    key_run = 1'b0;
    step(4);
    #2;
    clr = 1'b0;
    #1;
    chk_all("midrst", 2'b00, 1'b0, 1'b0);
    step(2);
    clr = 1'b1;
    chk({"midrst_rel.clr_n_before_edge"}, {1'b0, clr_n}, 2'b00);
    step(1);
    chk_all("midrst_rel", 2'b00, 1'b0, 1'b1);

    // Key held through reset release gives no event until re-pressed
    step(20);
    chk_all("held_rst", 2'b00, 1'b0, 1'b1);
    key_run = 1'b1;
    step(12);
    chk_all("held_rst.release", 2'b00, 1'b0, 1'b1);
    key_run = 1'b0;
    step(12);
    chk_all("held_rst.repress", 2'b01, 1'b1, 1'b1);
    key_run = 1'b1;
    step(5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
